imu_spi_scheduler: RTL

- Sequences one shared 48-bit SPI read engine between the gyroscope and the accelerometer.
- After reset it waits a power-up delay, writes one config command to each sensor, then polls both sensors every SAMPLE_PERIOD cycles.
- Publishes each gyro/accel pair as one coherent sample with a one-cycle valid strobe.
- Sits between the sensor SPI engine and the game logic; dev_sel steers the engine's chip select to the addressed sensor.

---
 rtl/imu_spi_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imu_spi_scheduler.sv
// Shares one 48-bit SPI read engine between gyro and accel: power-up wait, one config
// write per sensor, then periodic paired reads published as one coherent sample.
module imu_spi_scheduler #(
    parameter int unsigned STARTUP_CYCLES = 2700,
    parameter int unsigned SAMPLE_PERIOD  = 27000,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [15:0] GYRO_CFG       = 16'h200F,
    parameter logic [15:0] ACCEL_CFG      = 16'h2067,
    parameter logic [15:0] GYRO_RD        = 16'hE800,
    parameter logic [15:0] ACCEL_RD       = 16'hE800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        spi_start,
    output logic [15:0] spi_command,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    input  logic [47:0] spi_data,
    output logic        dev_sel,
    output logic [47:0] gyro_data,
    output logic [47:0] accel_data,
    output logic        sample_valid,
    output logic        init_done,
    output logic        timeout_err
);
    typedef enum logic [2:0] {STARTUP, CFG_G, CFG_A, WAIT, RD_G, RD_A, PUBLISH} state_t;
    typedef enum logic {ISSUE, DONE} phase_t;

    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PW = (SAMPLE_PERIOD  > 1) ? $clog2(SAMPLE_PERIOD)  : 1;
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [TW-1:0] ACC_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST   = PW'(SAMPLE_PERIOD - 1);

    state_t        state, state_n;
    phase_t        phase, phase_n;
    logic [SW-1:0] start_cnt;
    logic [TW-1:0] acc_cnt;
    logic [PW-1:0] per_cnt;
    logic          new_data_q;
    logic [47:0]   gyro_hold, accel_hold;
    logic          in_access, acc_done, acc_timeout, poll_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= STARTUP;
            phase <= ISSUE;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n     = state;
        phase_n     = phase;
        spi_command = '0;
        dev_sel     = 1'b0;
        in_access   = 1'b1;
        case (state)
            CFG_G:   spi_command = GYRO_CFG;
            CFG_A: begin
                spi_command = ACCEL_CFG;
                dev_sel     = 1'b1;
            end
            RD_G:    spi_command = GYRO_RD;
            RD_A: begin
                spi_command = ACCEL_RD;
                dev_sel     = 1'b1;
            end
            default: in_access = 1'b0;
        endcase

        spi_start   = in_access && (phase == ISSUE);
        acc_done    = in_access && (phase == DONE) && spi_new_data && !new_data_q;
        acc_timeout = in_access && !acc_done && (acc_cnt == ACC_LAST);
        poll_go     = (state == WAIT) && (per_cnt >= PER_LAST) && enable;

        if (acc_timeout) begin
            state_n = STARTUP;
            phase_n = ISSUE;
        end else if (acc_done) begin
            phase_n = ISSUE;
            case (state)
                CFG_G:   state_n = CFG_A;
                CFG_A:   state_n = WAIT;
                RD_G:    state_n = RD_A;
                default: state_n = PUBLISH;
            endcase
        end else if (in_access) begin
            // A busy engine at ISSUE entry counts as an accepted start.
            if (phase == ISSUE && spi_busy) phase_n = DONE;
        end else begin
            case (state)
                STARTUP: if (start_cnt == START_LAST) state_n = CFG_G;
                WAIT:    if (poll_go) state_n = RD_G;
                PUBLISH: state_n = WAIT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_cnt    <= '0;
            acc_cnt      <= '0;
            per_cnt      <= '0;
            new_data_q   <= 1'b0;
            gyro_hold    <= '0;
            accel_hold   <= '0;
            gyro_data    <= '0;
            accel_data   <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            new_data_q   <= spi_new_data;
            sample_valid <= 1'b0;
            start_cnt    <= (state == STARTUP && state_n == STARTUP) ? start_cnt + 1'b1 : '0;
            acc_cnt      <= (in_access && state_n == state) ? acc_cnt + 1'b1 : '0;

            // Period counter measures from the last poll start and saturates at expiry.
            if (state == STARTUP || (state == CFG_A && acc_done) || poll_go || acc_timeout)
                per_cnt <= '0;
            else if (per_cnt < PER_LAST)
                per_cnt <= per_cnt + 1'b1;

            if (acc_done) begin
                case (state)
                    CFG_A:   init_done  <= 1'b1;
                    RD_G:    gyro_hold  <= spi_data;
                    RD_A:    accel_hold <= spi_data;
                    default: ;
                endcase
            end

            if (state == PUBLISH) begin
                gyro_data    <= gyro_hold;
                accel_data   <= accel_hold;
                sample_valid <= 1'b1;
            end

            if (acc_timeout) begin
                timeout_err <= 1'b1;
                init_done   <= 1'b0;
                gyro_hold   <= '0;
                accel_hold  <= '0;
            end
        end
    end
endmodule
